// File: rtl/cam_capture_pkg.sv
// Shared types and constants for the camera window capture path.
// Latency: n/a (declarations only).
// Backpressure: n/a; the pixel source cannot be stalled.
package cam_capture_pkg;

    // Capture FSM; the encoding is visible on state_dbg (LEDs).
    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } cap_state_t;

    localparam int DEF_SRC_W = 640;
    localparam int DEF_SRC_H = 480;

    // Position counters and window compares share this width, so an origin
    // near the top of the 10-bit range cannot wrap into a false hit.
    localparam int POS_W = 11;

    // RGB565 field positions within a 16-bit pixel.
    localparam int RGB565_R_LSB = 11;
    localparam int RGB565_R_W   = 5;
    localparam int RGB565_G_LSB = 5;
    localparam int RGB565_G_W   = 6;
    localparam int RGB565_B_LSB = 0;
    localparam int RGB565_B_W   = 5;

endpackage

// File: rtl/cam_pos_counter.sv
// Source X/Y position tracker with end-of-frame consistency check.
// Latency: h/v reflect pixels seen up to the previous clock.
// Backpressure: none; counts every pix_valid while enabled.
//
// Ports: clk, rst (sync, active high), en (count only once frame-synced),
// pix_valid, frame_done; outputs h, v position of the next pixel, and the
// sticky frame_error flag.
module cam_pos_counter
    import cam_capture_pkg::*;
#(
    parameter int SRC_W = DEF_SRC_W,
    parameter int SRC_H = DEF_SRC_H
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pix_valid,
    input  logic             frame_done,
    output logic [POS_W-1:0] h,
    output logic [POS_W-1:0] v,
    output logic             frame_error
);

    always_ff @(posedge clk) begin
        if (rst) begin
            h           <= '0;
            v           <= '0;
            frame_error <= 1'b0;
        end else if (frame_done) begin
            // A well-formed frame leaves the counters wrapped back to (0,0);
            // anything else is a short or long frame. Resync regardless.
            if (en && (h != '0 || v != '0))
                frame_error <= 1'b1;
            h <= '0;
            v <= '0;
        end else if (en && pix_valid) begin
            if (h == POS_W'(SRC_W - 1)) begin
                h <= '0;
                v <= (v == POS_W'(SRC_H - 1)) ? '0 : v + POS_W'(1);
            end else begin
                h <= h + POS_W'(1);
            end
        end
    end

endmodule

// File: rtl/cam_window_capture.sv
// Camera pixel stream to frame-buffer writer for a runtime-placed, optionally decimated window.
// Latency: 1 clk from pix_valid to wr_en/wr_addr/wr_data.
// Backpressure: none; buffer must accept one write per clk. Gating changes only at frame_done.
//
// Ports: clk, rst (sync, active high); cap_en, win_x0, win_y0 (sampled at
// frame_done); pix_valid, pix_data, frame_done (source stream); wr_en,
// wr_addr, wr_data (buffer write port); frame_captured (1-clk pulse),
// frame_error (sticky), state_dbg (FSM state).
// Optional: define SNAPSHOT_EN to add snap_req and single-shot capture via HOLD.
module cam_window_capture
    import cam_capture_pkg::*;
#(
    parameter int PIX_W      = 16,
    parameter int SRC_W      = DEF_SRC_W,
    parameter int SRC_H      = DEF_SRC_H,
    parameter int WIN_W      = 256,
    parameter int WIN_H      = 256,
    parameter int DECIM_LOG2 = 0,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_en,
    input  logic [9:0]        win_x0,
    input  logic [8:0]        win_y0,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              frame_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              frame_captured,
    output logic              frame_error,
    output logic [1:0]        state_dbg
`ifdef SNAPSHOT_EN
    ,
    input  logic              snap_req
`endif
);

    // One extra bit so the counter can sit at WIN_W*WIN_H when the window fills the address space.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] WIN_TOTAL = CNT_W'(WIN_W * WIN_H);
    localparam logic [POS_W:0]   SPAN_X    = (POS_W + 1)'(WIN_W << DECIM_LOG2);
    localparam logic [POS_W:0]   SPAN_Y    = (POS_W + 1)'(WIN_H << DECIM_LOG2);
    localparam logic [POS_W-1:0] DEC_MASK  = POS_W'((1 << DECIM_LOG2) - 1);

    cap_state_t       state_q, state_d;
    logic             latch_win;
    logic [CNT_W-1:0] addr;
    logic [9:0]       x0_l;
    logic [8:0]       y0_l;
    logic [POS_W-1:0] h, v;
    logic [POS_W-1:0] x0_ext, y0_ext, dx, dy;
    logic             in_win, addr_full, hit;

    cam_pos_counter #(
        .SRC_W (SRC_W),
        .SRC_H (SRC_H)
    ) u_pos (
        .clk         (clk),
        .rst         (rst),
        .en          (state_q != SYNC),
        .pix_valid   (pix_valid),
        .frame_done  (frame_done),
        .h           (h),
        .v           (v),
        .frame_error (frame_error)
    );

    // Window test on the position of the pixel currently presented.
    assign x0_ext    = {1'b0, x0_l};
    assign y0_ext    = {2'b0, y0_l};
    assign dx        = h - x0_ext;
    assign dy        = v - y0_ext;
    assign in_win    = (h >= x0_ext) && (v >= y0_ext)
                    && ({1'b0, dx} < SPAN_X) && ({1'b0, dy} < SPAN_Y)
                    && ((dx & DEC_MASK) == '0) && ((dy & DEC_MASK) == '0);
    assign addr_full = (addr == WIN_TOTAL);
    // frame_done takes priority over a coincident pixel, which is dropped.
    assign hit       = (state_q == CAPTURE) && pix_valid && !frame_done
                    && in_win && !addr_full;

    assign state_dbg = state_q;

    always_comb begin
        state_d   = state_q;
        latch_win = 1'b0;
        case (state_q)
            SYNC: begin
                if (frame_done)
                    state_d = ARMED;
            end
            ARMED: begin
                if (frame_done) begin
                    latch_win = 1'b1;
                    if (cap_en)
                        state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (frame_done) begin
                    latch_win = 1'b1;
                    if (!cap_en)
                        state_d = ARMED;
`ifdef SNAPSHOT_EN
                    else if (addr_full)
                        state_d = HOLD;
`endif
                end
            end
            HOLD: begin
`ifdef SNAPSHOT_EN
                if (snap_req)
                    state_d = ARMED;
`endif
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= SYNC;
            addr           <= '0;
            x0_l           <= '0;
            y0_l           <= '0;
            wr_en          <= 1'b0;
            wr_addr        <= '0;
            wr_data        <= '0;
            frame_captured <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_en          <= hit;
            frame_captured <= (state_q == CAPTURE) && frame_done && addr_full;
            if (latch_win) begin
                x0_l <= win_x0;
                y0_l <= win_y0;
            end
            if (frame_done) begin
                addr <= '0;
            end else if (hit) begin
                addr    <= addr + CNT_W'(1);
                wr_addr <= addr[ADDR_W-1:0];
                wr_data <= pix_data;
            end
        end
    end

endmodule

// File: doc/cam_window_capture.md
Name: cam_window_capture

Overview:
Parametrised successor to the fixed 256x256 camera-to-buffer write path. Consumes a pixel stream (valid strobe, data, frame-done) already in the `clk` domain and tracks source X/Y position over a parametrised source frame. Selects a runtime-positioned window, optionally decimated by 2^DECIM_LOG2, and drives linear write address/data/enable into a dual-port frame buffer. Capture gating takes effect only at frame boundaries, so frames are never torn.

Parameters:
- PIX_W, 16, pixel data width (RGB565 default).
- SRC_W, 640, source pixels per line.
- SRC_H, 480, source lines per frame.
- WIN_W, 256, stored window width, in output pixels.
- WIN_H, 256, stored window height, in output lines.
- DECIM_LOG2, 0, decimation exponent; keep 1 of every 2^DECIM_LOG2 pixels in X and in Y.
- ADDR_W, 16, buffer address width; must satisfy 2^ADDR_W >= WIN_W*WIN_H.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cap_en  in  1  capture enable (freeze when 0); sampled only at frame boundary.
- win_x0  in  10  window X origin in source pixels; sampled at frame boundary.
- win_y0  in  9  window Y origin in source lines; sampled at frame boundary.
- pix_valid  in  1  one-cycle strobe per source pixel.
- pix_data  in  PIX_W  pixel value, qualified by pix_valid.
- frame_done  in  1  one-cycle end-of-frame strobe.
- wr_en  out  1  buffer write enable.
- wr_addr  out  ADDR_W  linear buffer address.
- wr_data  out  PIX_W  buffer write data.
- frame_captured  out  1  one-cycle pulse: a full window was written.
- frame_error  out  1  sticky: a frame_done arrived with the position not at a line/frame end; cleared by rst.
- state_dbg  out  2  current FSM state, for the LEDs.

Behaviour:
- Reset: all outputs 0; counters h=0, v=0, addr=0; state SYNC.
- FSM states: SYNC=0, ARMED=1, CAPTURE=2, HOLD=3.
  - SYNC: wait for the first frame_done, then go to ARMED. Pixels are ignored.
  - ARMED: pixels are counted but not written. On frame_done, latch cap_en, win_x0 and win_y0. Go to CAPTURE if cap_en=1, else stay.
  - CAPTURE: write window pixels. On frame_done, pulse frame_captured if addr reached WIN_W*WIN_H, then re-latch the inputs. If cap_en=0, go to ARMED.
  - HOLD: used only with SNAPSHOT_EN.
- Position counters:
  - On pix_valid, h increments.
  - At h=SRC_W-1, h goes to 0 and v increments.
  - At v=SRC_H-1 with h=SRC_W-1, v goes to 0.
- Window test uses latched x0/y0.
  - dx=h-x0 and dy=v-y0 must be non-negative.
  - dx < WIN_W<<DECIM_LOG2 and dy < WIN_H<<DECIM_LOG2.
  - The low DECIM_LOG2 bits of both dx and dy must be 0.
  - Compare at 11-bit width, so no wrap-around false hits.
- A window extending past the source edge is clipped. The pixels beyond the edge are simply never written.
- Write timing: a pixel that passes the test in CAPTURE produces wr_en=1 for exactly one cycle, one clk after pix_valid (latency 1).
  - wr_data is the registered pix_data.
  - wr_addr is the current addr; addr then increments.
  - Writes stop once addr reaches WIN_W*WIN_H.
- frame_done resets h, v and addr to 0 in the same cycle.
- frame_done with pix_valid in the same cycle: frame_done wins and that pixel is dropped.
- frame_error is set if frame_done arrives while (h,v) != (0,0), i.e. a short or long frame. Counters still resync.
- rst mid-frame returns to SYNC; no partial write is issued after rst.

Optional Feature:
SNAPSHOT_EN.
- When defined: adds input snap_req (1 bit).
  - CAPTURE completing a frame goes to HOLD, which writes nothing.
  - snap_req in HOLD goes to ARMED, and the next frame boundary with cap_en=1 captures exactly one frame.
- When undefined: snap_req is absent, HOLD is unreachable, and capture is continuous.

Decomposition:
- Package cam_capture_pkg holds:
  - state enum (SYNC/ARMED/CAPTURE/HOLD) with its encoding;
  - default SRC_W/SRC_H constants;
  - RGB565 field-position constants.
- One natural sub-module: cam_pos_counter. It owns h/v, wrap and frame_error generation; the window/address logic stays in the top.

Test Plan:
1. Power-up mid-frame: rst, then 1000 pix_valid with no frame_done -> wr_en stays 0, state_dbg=0. After frame_done -> state_dbg=1.
2. Default window: x0=0, y0=0, cap_en=1, two full 640x480 frames -> second frame gives 65536 writes with addresses 0..65535, the pixel at (h=255,v=1) at addr 511, and one frame_captured pulse.
3. Offset and clip: x0=500, y0=300 -> 140 writes per line over 180 lines (25200 total), first addr 0, no frame_captured.
4. Decimation: DECIM_LOG2=1, window 256x240, x0=64 -> writes only for even dx/dy; the pixel at (h=66,v=2) lands at addr 257.
5. Freeze: cap_en dropped to 0 mid-frame -> writes continue until frame end, then stop. Raising it mid-frame -> writes start only after the next frame_done.
6. Short frame plus collision: frame_done at (h=10,v=100) coincident with pix_valid -> frame_error=1, pixel not written, next frame captures normally from addr 0.
